// File: rtl/sram_like_arbiter.sv
// Two-master sram-like arbiter: muxes IF and data requests onto one slave port and
// routes in-order responses back through an owner FIFO of accepted transactions.
module sram_like_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  output logic        proto_err
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(MAX_OUTSTANDING);
  localparam logic [SC_W-1:0]  SLIM     = SC_W'(STARVE_LIMIT);
  localparam logic             OWN_INST = 1'b0;
  localparam logic             OWN_DATA = 1'b1;

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  sram_req_t [1:0]          mreq;
  sram_req_t                sel;
  logic                     grant;
  logic                     locked;
  logic                     lock_owner;
  logic [SC_W-1:0]          starve_cnt;
  logic [MAX_OUTSTANDING-1:0] owner_q;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic                     head_owner;

  assign mreq[OWN_INST] = {inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
  assign mreq[OWN_DATA] = {data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata};

  // A pending (locked) address phase must finish on the same master before re-arbitrating.
  always_comb begin
    grant = OWN_INST;
    if (locked)
      grant = lock_owner;
    else if (data_req && !(inst_req && starve_cnt == SLIM))
      grant = OWN_DATA;
  end

  assign sel     = mreq[grant];
  assign full    = (count == DEPTH);
  assign empty   = (count == '0);

  assign s_req   = sel.req && !full && !reset;
  assign s_wr    = sel.wr;
  assign s_size  = sel.size;
  assign s_wstrb = sel.wstrb;
  assign s_addr  = sel.addr;
  assign s_wdata = sel.wdata;

  assign push         = s_req && s_addr_ok;
  assign inst_addr_ok = push && (grant == OWN_INST);
  assign data_addr_ok = push && (grant == OWN_DATA);

  assign head_owner   = owner_q[rd_ptr];
  assign pop          = s_data_ok && !empty && !reset;
  assign inst_data_ok = pop && (head_owner == OWN_INST);
  assign data_data_ok = pop && (head_owner == OWN_DATA);
  assign inst_rdata   = s_rdata;
  assign data_rdata   = s_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      locked     <= 1'b0;
      lock_owner <= OWN_INST;
    end else if (s_req && !s_addr_ok) begin
      locked     <= 1'b1;
      lock_owner <= grant;
    end else if (push) begin
      locked     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !inst_req)
      starve_cnt <= '0;
    else if (push && grant == OWN_INST)
      starve_cnt <= '0;
    else if (push && starve_cnt != SLIM)
      starve_cnt <= starve_cnt + SC_W'(1);
  end

  // Owner FIFO: push writes the tail while pop reads the old head in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        owner_q[wr_ptr] <= grant;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      proto_err <= 1'b0;
    else if (s_data_ok && empty)
      proto_err <= 1'b1;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: grant order, lock, starvation, FIFO full/empty, reset.
module tb_sram_like_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;
  logic        proto_err;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance past the next rising edge, then let new inputs settle before checking.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // One response cycle with no address traffic; checks routing to the expected owner.
  task automatic resp(input string tag, input logic to_data, input logic [31:0] rd);
    s_data_ok = 1'b1;
    s_rdata   = rd;
    settle();
    chk({tag, ".inst_data_ok"}, inst_data_ok, !to_data);
    chk({tag, ".data_data_ok"}, data_data_ok, to_data);
    chk({tag, ".rdata"}, to_data ? data_rdata : inst_rdata, rd);
    tick();
    s_data_ok = 1'b0;
  endtask

  initial begin
    logic exp_d;
    reset = 1'b1;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hF;
    inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'hF;
    data_addr = 32'h0; data_wdata = 32'h0;
    s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'h0;
    settle();
    chk("rst.s_req", s_req, 1'b0);
    chk("rst.inst_addr_ok", inst_addr_ok, 1'b0);
    chk("rst.inst_data_ok", inst_data_ok, 1'b0);
    tick(); tick();
    chk("rst.proto_err", proto_err, 1'b0);
    reset = 1'b0; inst_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
    tick();

    // 1: single inst fetch
    inst_req = 1'b1; inst_addr = 32'hBFC00000; s_addr_ok = 1'b1;
    settle();
    chk("t1.s_req", s_req, 1'b1);
    chk("t1.s_addr", s_addr, 32'hBFC00000);
    chk("t1.inst_addr_ok", inst_addr_ok, 1'b1);
    chk("t1.data_addr_ok", data_addr_ok, 1'b0);
    tick();
    inst_req = 1'b0; s_addr_ok = 1'b0;
    settle();
    chk("t1.idle_s_req", s_req, 1'b0);
    resp("t1.rsp", 1'b0, 32'h3C1D0001);

    // 2: simultaneous requests, data first, responses D then I
    inst_req = 1'b1; inst_addr = 32'h1000; data_req = 1'b1; data_addr = 32'h2000; s_addr_ok = 1'b1;
    settle();
    chk("t2.s_addr_d", s_addr, 32'h2000);
    chk("t2.data_addr_ok", data_addr_ok, 1'b1);
    chk("t2.inst_addr_ok0", inst_addr_ok, 1'b0);
    tick();
    data_req = 1'b0;
    settle();
    chk("t2.s_addr_i", s_addr, 32'h1000);
    chk("t2.inst_addr_ok", inst_addr_ok, 1'b1);
    tick();
    inst_req = 1'b0; s_addr_ok = 1'b0;
    resp("t2.rsp_d", 1'b1, 32'hD0D0D0D0);
    resp("t2.rsp_i", 1'b0, 32'h11111111);

    // 3: data locked while inst rises
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h3000; data_wdata = 32'hAAAA5555;
    settle();
    chk("t3.s_req", s_req, 1'b1);
    chk("t3.data_addr_ok0", data_addr_ok, 1'b0);
    tick();
    inst_req = 1'b1; inst_addr = 32'h4000;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("t3.lock_addr", s_addr, 32'h3000);
      chk("t3.lock_wdata", s_wdata, 32'hAAAA5555);
      chk("t3.lock_wr", s_wr, 1'b1);
      chk("t3.inst_addr_ok0", inst_addr_ok, 1'b0);
      tick();
    end
    s_addr_ok = 1'b1;
    settle();
    chk("t3.accept_addr", s_addr, 32'h3000);
    chk("t3.data_addr_ok", data_addr_ok, 1'b1);
    tick();
    data_req = 1'b0; data_wr = 1'b0;
    settle();
    chk("t3.inst_addr", s_addr, 32'h4000);
    chk("t3.inst_addr_ok", inst_addr_ok, 1'b1);
    tick();
    inst_req = 1'b0; s_addr_ok = 1'b0;
    resp("t3.rsp_d", 1'b1, 32'h33333333);
    resp("t3.rsp_i", 1'b0, 32'h44444444);

    // 3b: inst locked; data arriving later must not steal the grant
    inst_req = 1'b1; inst_addr = 32'h5000;
    settle();
    chk("t3b.s_addr_i", s_addr, 32'h5000);
    tick();
    data_req = 1'b1; data_addr = 32'h6000;
    settle();
    chk("t3b.lock_addr", s_addr, 32'h5000);
    chk("t3b.data_addr_ok0", data_addr_ok, 1'b0);
    tick();
    s_addr_ok = 1'b1;
    settle();
    chk("t3b.inst_addr_ok", inst_addr_ok, 1'b1);
    tick();
    inst_req = 1'b0;
    settle();
    chk("t3b.s_addr_d", s_addr, 32'h6000);
    chk("t3b.data_addr_ok", data_addr_ok, 1'b1);
    tick();
    data_req = 1'b0; s_addr_ok = 1'b0;
    resp("t3b.rsp_i", 1'b0, 32'h55555555);
    resp("t3b.rsp_d", 1'b1, 32'h66666666);

    // 4: both always requesting -> D,D,D,D,I repeating; one response per cycle keeps FIFO at 1
    inst_req = 1'b1; inst_addr = 32'hA000; data_req = 1'b1; data_addr = 32'hB000; s_addr_ok = 1'b1;
    exp_d = 1'b0;
    for (int k = 0; k < 10; k++) begin
      s_data_ok = (k > 0);
      settle();
      if (k > 0) begin
        chk("t4.rsp_data_ok", data_data_ok, exp_d);
        chk("t4.rsp_inst_ok", inst_data_ok, !exp_d);
      end
      exp_d = ((k % 5) != 4);
      chk("t4.grant_addr", s_addr, exp_d ? 32'hB000 : 32'hA000);
      chk("t4.data_addr_ok", data_addr_ok, exp_d);
      chk("t4.inst_addr_ok", inst_addr_ok, !exp_d);
      tick();
    end
    inst_req = 1'b0; data_req = 1'b0; s_addr_ok = 1'b0;
    resp("t4.drain_i", 1'b0, 32'h77777777);

    // 5: fill to 4, full masks s_req, simultaneous push/pop keeps count, refill to full
    data_req = 1'b1; data_addr = 32'hC000; s_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t5.fill_addr_ok", data_addr_ok, 1'b1);
      tick();
    end
    settle();
    chk("t5.full_s_req", s_req, 1'b0);
    chk("t5.full_addr_ok", data_addr_ok, 1'b0);
    s_data_ok = 1'b1; s_rdata = 32'hD1;
    settle();
    chk("t5.pop_full_s_req", s_req, 1'b0);
    chk("t5.pop_full_dok", data_data_ok, 1'b1);
    tick();
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'hE000; s_rdata = 32'hD2;
    settle();
    chk("t5.pushpop_inst_aok", inst_addr_ok, 1'b1);
    chk("t5.pushpop_data_dok", data_data_ok, 1'b1);
    tick();
    inst_req = 1'b0; data_req = 1'b1; s_data_ok = 1'b0;
    settle();
    chk("t5.refill_aok", data_addr_ok, 1'b1);
    tick();
    settle();
    chk("t5.refull_s_req", s_req, 1'b0);
    data_req = 1'b0; s_addr_ok = 1'b0;
    resp("t5.rsp_d3", 1'b1, 32'hD3);
    resp("t5.rsp_d4", 1'b1, 32'hD4);
    resp("t5.rsp_i", 1'b0, 32'hE1);
    resp("t5.rsp_d5", 1'b1, 32'hD5);

    // 6: response with empty FIFO, then reset with outstanding transactions
    chk("t6.proto_err0", proto_err, 1'b0);
    s_data_ok = 1'b1; s_rdata = 32'hBAD;
    settle();
    chk("t6.empty_inst_dok", inst_data_ok, 1'b0);
    chk("t6.empty_data_dok", data_data_ok, 1'b0);
    tick();
    s_data_ok = 1'b0;
    tick(); tick();
    chk("t6.proto_err_sticky", proto_err, 1'b1);
    data_req = 1'b1; data_addr = 32'hF000; s_addr_ok = 1'b1;
    tick(); tick();
    reset = 1'b1;
    settle();
    chk("t6.rst_s_req", s_req, 1'b0);
    chk("t6.rst_addr_ok", data_addr_ok, 1'b0);
    tick();
    reset = 1'b0; data_req = 1'b0; s_addr_ok = 1'b0;
    settle();
    chk("t6.post_rst_proto", proto_err, 1'b0);
    chk("t6.post_rst_s_req", s_req, 1'b0);
    s_data_ok = 1'b1;
    settle();
    chk("t6.dropped_dok", data_data_ok, 1'b0);
    tick();
    s_data_ok = 1'b0;
    settle();
    chk("t6.proto_err_again", proto_err, 1'b1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
